// File: rtl/axi4_burst_master.sv
// Purpose : single-outstanding AXI4 INCR burst master; command port in, AXI4 write/read channels out.
// Latency : accept->AxVALID 1 cycle; W/R beats pass through combinationally; done 1 cycle after B/last R.
// Backpres: wr/rd beat streams map straight onto WREADY / rd_ready; cmd_ready low from accept until done.
//
// Ports   : ACLK/ARESET (sync, active-high); cmd_* burst request; wr_* write beat stream in;
//           rd_* read beat stream out; done/err/resp completion status; AW/W/B/AR/R AXI4 master channels.
// Option  : define AXI_MASTER_4KB_CHECK_EN to reject bursts crossing a 4 KB page (done with err=1,
//           no AXI traffic). Undefined: every command is issued as given.
module axi4_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // write beat stream
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // read beat stream
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    // completion
    output logic                  done,
    output logic                  err,
    output logic [1:0]            resp,
    // AXI write address
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    // AXI write data
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    // AXI write response
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    // AXI read address
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    // AXI read data
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
);

    localparam int         BYTES  = DATA_WIDTH / 8;
    localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  err_q, err_d;
    logic [1:0]            resp_q, resp_d;
    logic                  last_beat;
    logic                  reject;

`ifdef AXI_MASTER_4KB_CHECK_EN
    // Byte offset one past the final beat, relative to the 4 KB page start.
    logic [31:0] burst_end;
    assign burst_end = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) * 32'(BYTES));
    assign reject    = (burst_end > 32'd4096);
`else
    assign reject = 1'b0;
`endif

    // Exit test uses the count before increment, so len=255 needs no 9th bit.
    assign last_beat = (beat_cnt_q == len_q);

    // Address/length registers feed both channels; only one VALID is ever high.
    assign AWADDR = addr_q;
    assign ARADDR = addr_q;
    assign AWLEN  = len_q;
    assign ARLEN  = len_q;
    assign AWSIZE = AXSIZE;
    assign ARSIZE = AXSIZE;
    assign WDATA  = wr_data;
    assign rd_data = RDATA;
    assign err    = err_q;
    assign resp   = resp_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            resp_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        resp_d     = resp_q;
        cmd_ready  = 1'b0;
        AWVALID    = 1'b0;
        WVALID     = 1'b0;
        WLAST      = 1'b0;
        wr_ready   = 1'b0;
        BREADY     = 1'b0;
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    err_d      = 1'b0;
                    resp_d     = 2'b00;
                    if (reject) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (cmd_write) begin
                        state_d = S_AW;
                    end else begin
                        state_d = S_AR;
                    end
                end
            end
            S_AW: begin
                AWVALID = 1'b1;
                if (AWREADY) state_d = S_W;
            end
            S_W: begin
                WVALID   = wr_valid;
                wr_ready = WREADY;
                WLAST    = last_beat;
                if (wr_valid && WREADY) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last_beat) state_d = S_B;
                end
            end
            S_B: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    resp_d  = BRESP;
                    err_d   = (BRESP != 2'b00);
                    state_d = S_DONE;
                end
            end
            S_AR: begin
                ARVALID = 1'b1;
                if (ARREADY) state_d = S_R;
            end
            S_R: begin
                rd_valid = RVALID;
                rd_last  = RLAST;
                RREADY   = rd_ready;
                if (RVALID && rd_ready) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Stop at whichever end marker arrives first; disagreement is an error.
                    if (RLAST || last_beat) begin
                        err_d   = (RLAST != last_beat);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/axi4_burst_master.md
# axi4_burst_master

AXI4 burst master that sits directly upstream of `axi4_full_slave` and drives its write-address, write-data, write-response, read-address and read-data channels. A simple command port issues one INCR burst at a time. Write beats stream in through a valid/ready port, and read beats stream out through one. Each burst ends with a single-cycle completion pulse carrying status.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width; AxSIZE is fixed to log2(DATA_WIDTH/8), which is 3'b010 at 32

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_WIDTH  burst start address, aligned to DATA_WIDTH/8
- cmd_len  in  8  beats minus one (AXI LEN encoding)
- wr_data / wr_valid / wr_ready  in / in / out  DATA_WIDTH / 1 / 1  write beat stream
- rd_data / rd_valid / rd_last / rd_ready  out / out / out / in  DATA_WIDTH / 1 / 1 / 1  read beat stream
- done  out  1  one-cycle pulse at burst completion
- err  out  1  valid with done: 1 = BRESP≠OKAY, RLAST misplaced, or rejected burst
- resp  out  2  BRESP captured on writes; 2'b00 on reads
- AWADDR, AWLEN, AWSIZE, AWVALID, AWREADY  out, out, out, out, in  AXI write-address channel
- WDATA, WVALID, WLAST, WREADY  out, out, out, in  AXI write-data channel
- BRESP, BVALID, BREADY  in, in, out  AXI write-response channel
- ARADDR, ARLEN, ARSIZE, ARVALID, ARREADY  out, out, out, out, in  AXI read-address channel
- RDATA, RVALID, RLAST, RREADY  in, in, in, out  AXI read-data channel

## Operation
- FSM states: IDLE, AW, W, B, AR, R, DONE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch addr/len, clear beat_cnt, go to AW (write) or AR (read).
- AW / AR
  - AxVALID=1 with latched AxADDR/AxLEN. AxVALID, AxADDR and AxLEN stay stable until AxREADY.
  - On handshake, go to W / R.
- W (combinational pass-through)
  - WVALID=wr_valid, wr_ready=WREADY, WDATA=wr_data, WLAST=(beat_cnt==len).
  - beat_cnt increments on each WVALID&&WREADY.
  - Handshake with WLAST=1 moves to B.
- B
  - BREADY=1.
  - On BVALID, capture BRESP into resp and set err=(BRESP!=2'b00), then go to DONE.
- R (pass-through)
  - rd_valid=RVALID, rd_data=RDATA, rd_last=RLAST, RREADY=rd_ready.
  - beat_cnt increments per handshake.
  - Leave to DONE on the first handshake where RLAST=1 or beat_cnt==len.
  - err=1 if those two conditions do not coincide.
- DONE
  - done=1 for exactly one cycle, then go to IDLE.
  - err and resp hold their values until the next command is accepted.
- Only one burst is outstanding at a time. Writes and reads never overlap.
- beat_cnt is 8 bits. len=255 gives 256 beats with no overflow, because the exit condition is checked before the increment.

## Timing
- Reset values:
  - FSM=IDLE, cmd_ready=1.
  - All AXI VALID/READY outputs=0, AWADDR/ARADDR=0, AWLEN/ARLEN=0.
  - AWSIZE/ARSIZE=constant, WLAST=0.
  - rd_valid=0, wr_ready=0, done=0, err=0, resp=0.
- Command accepted at edge N: AxVALID is high from cycle N+1. cmd_ready is low from N+1 until done has pulsed.
- W/R pass-through adds zero latency. Each beat transfers in the cycle both sides are ready.
- Write, zero-wait slave: command edge to done is 1 (AW) + len+1 (W) + 1 (B) + 1 (DONE) cycles.
- Read, zero-wait slave: 1 (AR) + len+1 (R) + 1 (DONE) cycles.
- No new command is accepted in the DONE cycle. The earliest back-to-back accept is the cycle after done.
- Reset mid-burst: ARESET has priority on any edge. All outputs return to reset values in the next cycle, and the in-flight burst is abandoned without a done pulse.

## Configuration
- `AXI_MASTER_4KB_CHECK_EN` defined:
  - Any command where cmd_addr[11:0] + (len+1)·(DATA_WIDTH/8) > 4096 is accepted.
  - It then goes IDLE→DONE with no AXI traffic and err=1.
- Undefined: every command is issued as given.

## Test plan
- Write, addr 0x0, len=3, data A0..A3, slave zero-wait:
  - AWLEN=3, AWSIZE=3'b010.
  - WLAST high only on A3.
  - done 7 cycles after accept, err=0, resp=00.
- Read-back, addr 0x0, len=3:
  - rd_data A0..A3 in order, rd_last on A3.
  - done with err=0, 6 cycles after accept under zero-wait.
- Single beat, len=0, write 0xDEADBEEF to 0x10, then read it back:
  - WLAST and RLAST are both asserted on the only beat.
  - Read returns 0xDEADBEEF.
- Backpressure:
  - AWREADY held low 3 cycles: AWVALID/AWADDR remain stable.
  - wr_valid gapped every other cycle: WLAST still lands only on beat 4.
  - rd_ready low 2 cycles: RREADY follows and no beats are lost.
- Response error, BRESP=2'b10: done with err=1, resp=10.
- Reset and boundary check:
  - ARESET asserted after beat 2 of a 4-beat write: outputs are at reset values the next cycle, no done pulse, and the next command works.
  - With the macro defined, addr 0xFF8, len=3 gives done with err=1 and no AWVALID.
